// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its timeout counter.
package instr_fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_BR = 3'd3,
        ST_FAULT   = 3'd4
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam logic [31:0] IFU_RESET_PC    = 32'h0000_0000;
    localparam int unsigned IFU_ACK_TIMEOUT = 16;

    // Captured fetch result handed to decode.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_pkt_t;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Purpose: counts cycles an imem request waits unacknowledged; flags expiry at ACK_TIMEOUT-1.
// Latency: expire is combinational from the count; count updates one cycle after enable.
// Backpressure: none; clear has priority, count holds once expired.
module fetch_timeout_counter
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = IFU_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(ACK_TIMEOUT - 1);

    logic [7:0] cnt_q;

    assign expire = (cnt_q == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else if (clear) begin
            cnt_q <= 8'd0;
        end else if (enable && !expire) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, fetches one instruction at a time and hands {instr, pc} to decode; IFU_LINK_REG_EN adds a link register.
// Latency: imem_ack -> instr_valid 1 cycle; pc_next_valid -> imem_req 1 cycle; one instruction in flight.
// Backpressure: imem_req held until imem_ack; instr_valid held until instr_ready; no new fetch before next-PC resolves.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = IFU_RESET_PC,
    parameter int unsigned ACK_TIMEOUT = IFU_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [31:0] pc_next,
    input  logic        pc_next_valid,
    output logic [31:0] pc,
`ifdef IFU_LINK_REG_EN
    input  logic        link_we,
    output logic [31:0] link_addr,
`endif
    output logic        fault,
    output logic [1:0]  fault_code
);

    fetch_state_t state_q, state_nxt;
    fetch_pkt_t   pkt_q;
    logic [31:0]  pc_q;
    logic [1:0]   fault_code_q;

    logic tmo_expire;
    logic cap_fire;
    logic br_fire;
    logic br_ok;
    logic br_misalign;
    logic tmo_fault;

    fetch_timeout_counter #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != ST_REQ),
        .enable ((state_q == ST_REQ) && !imem_ack),
        .expire (tmo_expire)
    );

    // Event strobes; ack beats a timeout that expires in the same cycle.
    always_comb begin
        cap_fire    = (state_q == ST_REQ) && imem_ack;
        tmo_fault   = (state_q == ST_REQ) && !imem_ack && tmo_expire;
        br_fire     = (state_q == ST_WAIT_BR) && pc_next_valid;
        br_ok       = br_fire && word_aligned(pc_next[1:0]);
        br_misalign = br_fire && !word_aligned(pc_next[1:0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_en) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (cap_fire)       state_nxt = ST_ISSUE;
                else if (tmo_fault) state_nxt = ST_FAULT;
            end
            ST_ISSUE: begin
                if (instr_ready) state_nxt = ST_WAIT_BR;
            end
            ST_WAIT_BR: begin
                // fetch_en is only sampled here, so a stop never cuts an instruction short.
                if (br_misalign)   state_nxt = ST_FAULT;
                else if (br_ok)    state_nxt = fetch_en ? ST_REQ : ST_IDLE;
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (br_ok) begin
            pc_q <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_q <= '0;
        end else if (cap_fire) begin
            pkt_q.instr <= imem_rdata;
            pkt_q.pc    <= pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_code_q <= FAULT_NONE;
        end else if (tmo_fault) begin
            fault_code_q <= FAULT_TIMEOUT;
        end else if (br_misalign) begin
            fault_code_q <= FAULT_MISALIGN;
        end
    end

`ifdef IFU_LINK_REG_EN
    logic [31:0] link_q;

    // Return address of the instruction whose branch is resolving now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            link_q <= 32'd0;
        end else if (br_ok && link_we) begin
            link_q <= pkt_q.pc + 32'd4;
        end
    end

    assign link_addr = link_q;
`endif

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = pkt_q.instr;
    assign instr_pc    = pkt_q.pc;
    assign instr_valid = (state_q == ST_ISSUE);
    assign fault       = (state_q == ST_FAULT);
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random latencies and branch targets against a PC/memory model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc_next = 32'd0;
    logic        pc_next_valid = 1'b0;
    logic [31:0] pc;
    logic        fault;
    logic [1:0]  fault_code;
`ifdef IFU_LINK_REG_EN
    logic        link_we = 1'b0;
    logic [31:0] link_addr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural PC and a lazily filled instruction memory.
    logic [31:0] model_pc;
    logic [31:0] mem [logic [31:0]];

    // Observations recorded by the driver for the test tasks to judge.
    int          ob_req_wait;
    logic        ob_req_seen, ob_req_held, ob_valid_1cyc, ob_stall_ok, ob_valid_drop;
    logic        ob_req_after, ob_fault;
    logic [1:0]  ob_fcode;
    logic [31:0] ob_addr, ob_instr, ob_ipc, ob_pc_after, ob_addr_after;

    instr_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_next       (pc_next),
        .pc_next_valid (pc_next_valid),
        .pc            (pc),
`ifdef IFU_LINK_REG_EN
        .link_we       (link_we),
        .link_addr     (link_addr),
`endif
        .fault         (fault),
        .fault_code    (fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        fetch_en = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; pc_next_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_pc = RESET_PC;
    endtask

    // Plays memory, decode and branch stage for one instruction; records what it saw.
    task automatic fetch_one(input int ack_dly, input int rdy_dly, input logic [31:0] nxt,
                             input logic fen_after, input logic lw);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin @(negedge clk); n++; end
        ob_req_wait = n;
        ob_req_seen = imem_req;
        ob_addr     = imem_addr;
        if (!ob_req_seen) return;
        ob_req_held = 1'b1;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            if (!imem_req || imem_addr !== ob_addr) ob_req_held = 1'b0;
        end
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        ob_valid_1cyc = instr_valid;
        ob_instr = instr;
        ob_ipc = instr_pc;
        ob_stall_ok = 1'b1;
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            if (!instr_valid || instr !== ob_instr || instr_pc !== ob_ipc || imem_req)
                ob_stall_ok = 1'b0;
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        ob_valid_drop = !instr_valid && !imem_req;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        pc_next = nxt;
        pc_next_valid = 1'b1;
        fetch_en = fen_after;
`ifdef IFU_LINK_REG_EN
        link_we = lw;
`else
        if (lw) $display("note: link_we requested without link register");
`endif
        @(negedge clk);
        pc_next_valid = 1'b0;
        pc_next = $urandom;
`ifdef IFU_LINK_REG_EN
        link_we = 1'b0;
`endif
        ob_pc_after   = pc;
        ob_req_after  = imem_req;
        ob_addr_after = imem_addr;
        ob_fault      = fault;
        ob_fcode      = fault_code;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
        n_checks++; if ({imem_req, instr_valid, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {imem_req, instr_valid, fault}); end
        n_checks++; if ({instr, instr_pc} !== 64'd0) begin n_fail++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc); end
        n_checks++; if (fault_code !== 2'b00) begin n_fail++; $display("FAIL reset_fault_code: got %b want 00", fault_code); end
        do_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_without_fetch_en: imem_req got %b want 0", imem_req); end
    endtask

    task automatic test_zero_wait();
        mem[32'h0] = 32'h1234_5678;
        fetch_en = 1'b1;
        fetch_one(0, 0, 32'h4, 1'b1, 1'b0);
        n_checks++; if (ob_req_wait !== 1) begin n_fail++; $display("FAIL zw_req_latency: got %0d want 1", ob_req_wait); end
        n_checks++; if (ob_addr !== 32'h0) begin n_fail++; $display("FAIL zw_addr: got %h want 0", ob_addr); end
        n_checks++; if (ob_valid_1cyc !== 1'b1) begin n_fail++; $display("FAIL zw_valid_after_ack: got %b want 1", ob_valid_1cyc); end
        n_checks++; if (ob_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL zw_instr: got %h want 12345678", ob_instr); end
        n_checks++; if (ob_ipc !== 32'h0) begin n_fail++; $display("FAIL zw_instr_pc: got %h want 0", ob_ipc); end
        n_checks++; if (ob_valid_drop !== 1'b1) begin n_fail++; $display("FAIL zw_valid_drop: got %b want 1", ob_valid_drop); end
        n_checks++; if ({ob_req_after, ob_addr_after} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL zw_next_req: got %b/%h want 1/00000004", ob_req_after, ob_addr_after); end
        model_pc = 32'h4;
    endtask

    task automatic test_taken_branch();
        fetch_one(1, 0, 32'h8, 1'b1, 1'b0);
        model_pc = 32'h8;
        fetch_one(int'($urandom_range(0, 5)), 0, 32'h40, 1'b1, 1'b0);
        n_checks++; if (ob_ipc !== 32'h8) begin n_fail++; $display("FAIL br_instr_pc: got %h want 8", ob_ipc); end
        n_checks++; if (ob_pc_after !== 32'h40) begin n_fail++; $display("FAIL br_pc: got %h want 40", ob_pc_after); end
        n_checks++; if ({ob_req_after, ob_addr_after} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL br_next_req: got %b/%h want 1/00000040", ob_req_after, ob_addr_after); end
        model_pc = 32'h40;
    endtask

    task automatic test_decode_stall();
        fetch_one(2, 5, 32'h44, 1'b1, 1'b0);
        n_checks++; if (ob_stall_ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got %b want 1", ob_stall_ok); end
        n_checks++; if (ob_instr !== mem_word(model_pc)) begin n_fail++; $display("FAIL stall_instr: got %h want %h", ob_instr, mem_word(model_pc)); end
        n_checks++; if (ob_req_held !== 1'b1) begin n_fail++; $display("FAIL stall_req_held: got %b want 1", ob_req_held); end
        model_pc = 32'h44;
    endtask

    task automatic test_ack_boundary();
        // Ack on the very cycle the timeout would fire must still win.
        fetch_one(ACK_TIMEOUT - 1, 0, 32'h48, 1'b1, 1'b0);
        n_checks++; if (ob_valid_1cyc !== 1'b1) begin n_fail++; $display("FAIL ack_at_expiry_valid: got %b want 1", ob_valid_1cyc); end
        n_checks++; if ({ob_fault, ob_fcode} !== 3'b000) begin n_fail++; $display("FAIL ack_at_expiry_fault: got %b/%b want 0/00", ob_fault, ob_fcode); end
        n_checks++; if (ob_instr !== mem_word(model_pc)) begin n_fail++; $display("FAIL ack_at_expiry_instr: got %h want %h", ob_instr, mem_word(model_pc)); end
        model_pc = 32'h48;
    endtask

    task automatic test_fetch_en_stop();
        logic idle_ok;
        fetch_en = 1'b0;
        fetch_one(3, 1, 32'h80, 1'b0, 1'b0);
        n_checks++; if (ob_instr !== mem_word(model_pc)) begin n_fail++; $display("FAIL stop_completes_instr: got %h want %h", ob_instr, mem_word(model_pc)); end
        n_checks++; if ({ob_req_after, ob_pc_after} !== {1'b0, 32'h80}) begin n_fail++; $display("FAIL stop_to_idle: got %b/%h want 0/00000080", ob_req_after, ob_pc_after); end
        model_pc = 32'h80;
        idle_ok = 1'b1;
        repeat (4) begin @(negedge clk); if (imem_req) idle_ok = 1'b0; end
        n_checks++; if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL stop_stays_idle: got %b want 1", idle_ok); end
        fetch_en = 1'b1;
        fetch_one(0, 0, 32'h84, 1'b1, 1'b0);
        n_checks++; if (ob_addr !== model_pc) begin n_fail++; $display("FAIL restart_addr: got %h want %h", ob_addr, model_pc); end
        model_pc = 32'h84;
    endtask

    task automatic test_wrap();
        fetch_one(0, 0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        model_pc = 32'hFFFF_FFFC;
        fetch_one(1, 0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (ob_ipc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_instr_pc: got %h want fffffffc", ob_ipc); end
        n_checks++; if ({ob_fault, ob_addr_after} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL wrap_next: got %b/%h want 0/00000000", ob_fault, ob_addr_after); end
        model_pc = 32'h0;
    endtask

`ifdef IFU_LINK_REG_EN
    task automatic test_link();
        fetch_one(0, 0, 32'h100, 1'b1, 1'b0);
        model_pc = 32'h100;
        fetch_one(0, 0, 32'h200, 1'b1, 1'b1);
        n_checks++; if (link_addr !== 32'h104) begin n_fail++; $display("FAIL link_addr: got %h want 00000104", link_addr); end
        n_checks++; if (ob_pc_after !== 32'h200) begin n_fail++; $display("FAIL link_pc: got %h want 00000200", ob_pc_after); end
        model_pc = 32'h200;
        fetch_one(0, 0, 32'h204, 1'b1, 1'b0);
        n_checks++; if (link_addr !== 32'h104) begin n_fail++; $display("FAIL link_hold: got %h want 00000104", link_addr); end
        model_pc = 32'h204;
    endtask
`endif

    task automatic test_random();
        logic [31:0] nxt, exp_instr;
        for (int t = 0; t < 30; t++) begin
            nxt = ($urandom_range(0, 1) == 0) ? model_pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
            exp_instr = mem_word(model_pc);
            fetch_one(int'($urandom_range(0, ACK_TIMEOUT - 2)), int'($urandom_range(0, 3)), nxt, 1'b1, 1'b0);
            n_checks++; if ({ob_req_seen, ob_addr} !== {1'b1, model_pc}) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %b/%h want 1/%h", t, ob_req_seen, ob_addr, model_pc); end
            n_checks++; if ({ob_instr, ob_ipc} !== {exp_instr, model_pc}) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h/%h want %h/%h", t, ob_instr, ob_ipc, exp_instr, model_pc); end
            n_checks++; if ({ob_req_held, ob_valid_1cyc, ob_stall_ok, ob_valid_drop} !== 4'b1111) begin n_fail++; $display("FAIL rnd_handshake[%0d]: got %b want 1111", t, {ob_req_held, ob_valid_1cyc, ob_stall_ok, ob_valid_drop}); end
            n_checks++; if ({ob_req_after, ob_pc_after, ob_addr_after} !== {1'b1, nxt, nxt}) begin n_fail++; $display("FAIL rnd_next[%0d]: got %b/%h/%h want 1/%h", t, ob_req_after, ob_pc_after, ob_addr_after, nxt); end
            model_pc = nxt;
        end
    endtask

    task automatic test_misaligned();
        logic quiet;
        fetch_one(0, 0, 32'h0000_0042, 1'b1, 1'b0);
        n_checks++; if ({ob_fault, ob_fcode} !== 3'b101) begin n_fail++; $display("FAIL misalign_fault: got %b/%b want 1/01", ob_fault, ob_fcode); end
        n_checks++; if (ob_pc_after !== model_pc) begin n_fail++; $display("FAIL misalign_pc_kept: got %h want %h", ob_pc_after, model_pc); end
        @(negedge clk);
        pc_next = 32'h300; pc_next_valid = 1'b1; fetch_en = 1'b1;
        @(negedge clk);
        pc_next_valid = 1'b0;
        quiet = 1'b1;
        repeat (3) begin @(negedge clk); if (imem_req || instr_valid || !fault) quiet = 1'b0; end
        n_checks++; if ({quiet, pc} !== {1'b1, model_pc}) begin n_fail++; $display("FAIL fault_sticky: got %b/%h want 1/%h", quiet, pc, model_pc); end
        reset = 1'b0;
        #1;
        n_checks++; if ({pc, fault, fault_code} !== {RESET_PC, 1'b0, 2'b00}) begin n_fail++; $display("FAIL reset_from_fault: got %h/%b/%b want %h/0/00", pc, fault, fault_code, RESET_PC); end
        do_reset();
    endtask

    task automatic test_timeout();
        int n;
        logic quiet;
        fetch_en = 1'b1;
        n = 0;
        while (!imem_req && n < 5) begin @(negedge clk); n++; end
        n = 0;
        while (!fault && n < 40) begin @(negedge clk); n++; end
        n_checks++; if (n !== ACK_TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", n, ACK_TIMEOUT); end
        n_checks++; if (fault_code !== 2'b10) begin n_fail++; $display("FAIL timeout_code: got %b want 10", fault_code); end
        quiet = 1'b1;
        repeat (5) begin @(negedge clk); if (imem_req || !fault) quiet = 1'b0; end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL timeout_req_low: got %b want 1", quiet); end
        do_reset();
    endtask

    task automatic test_reset_mid_req();
        int n;
        fetch_en = 1'b1;
        n = 0;
        while (!imem_req && n < 5) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if ({imem_req, pc} !== {1'b0, RESET_PC}) begin n_fail++; $display("FAIL reset_mid_req: got %b/%h want 0/%h", imem_req, pc, RESET_PC); end
        do_reset();
        fetch_en = 1'b1;
        fetch_one(0, 0, 32'h10, 1'b1, 1'b0);
        n_checks++; if ({ob_addr, ob_instr} !== {RESET_PC, mem_word(RESET_PC)}) begin n_fail++; $display("FAIL refetch_after_reset: got %h/%h want %h/%h", ob_addr, ob_instr, RESET_PC, mem_word(RESET_PC)); end
    endtask

    initial begin
        model_pc = RESET_PC;
        test_reset();
        test_zero_wait();
        test_taken_branch();
        test_decode_stall();
        test_ack_boundary();
        test_fetch_en_stop();
        test_wrap();
`ifdef IFU_LINK_REG_EN
        test_link();
`endif
        test_random();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
